// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbitration logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Byte width of the uart_top transmit path.
  localparam int UART_DATA_W = 8;

  // Default abort threshold: about two 9600-baud frames at 1 MHz.
  localparam int DEFAULT_TIMEOUT_CYC = 2048;

  // Increment an index modulo n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin priority select: first set request bit at or after i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the grant.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any_req
);

  // Scan ptr, ptr+1, ... modulo N; the first set bit wins.
  always_comb begin
    int w_idx;
    w_idx     = 0;
    o_grant   = '0;
    o_any_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req = 1'b1;
        o_grant   = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Latency: req in IDLE at N -> send at N+1; tx_done at M -> ack/err at M+1; next send >= M+3.
// Backpressure: requesters hold req until their ack/err pulse; one transfer in flight at a time.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       send,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_pick;
  logic               w_any_req;
  logic [DATA_W-1:0]  r_tx_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ok;
  logic               w_timeout;
  logic               w_send;
  logic [NUM_REQ-1:0] w_ack;
  logic [NUM_REQ-1:0] w_err;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_grant   (w_pick),
    .o_any_req (w_any_req)
  );

  // The wait counter exits WAIT before it can wrap, so no saturation logic is needed.
  assign w_timeout = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and one-cycle strobes; tx_done only matters in WAIT and beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_send       = 1'b0;
    w_ack        = '0;
    w_err        = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_next_state = LAUNCH;
      end
      LAUNCH: begin
        w_send       = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (tx_done || w_timeout) w_next_state = DONE;
      end
      DONE: begin
        if (r_ok) w_ack[r_grant] = 1'b1;
        else      w_err[r_grant] = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Grant/data latch, wait counter, outcome flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_ok      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant   <= w_pick;
            r_tx_data <= req_data[int'(w_pick)*DATA_W +: DATA_W];
          end
        end
        LAUNCH: begin
          r_cnt <= '0;
          r_ok  <= 1'b0;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (tx_done) r_ok <= 1'b1;
        end
        DONE: begin
          r_ptr <= IDX_W'(wrap_inc(int'(r_grant), NUM_REQ));
        end
        default: ;
      endcase
    end
  end

  assign send     = w_send;
  assign ack      = w_ack;
  assign err      = w_err;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a scoreboard of expected grants.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic              send;
  logic [DW-1:0]     tx_data;
  logic              tx_done;
  logic              busy;
  logic [1:0]        grant_id;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         ok;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NREQ),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .send     (send),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int id, input logic [7:0] data, input bit ok);
    exp_t e;
    e.id = id; e.data = data; e.ok = ok;
    exp_q.push_back(e);
  endtask

  // Wait for send, act as uart_top (tx_done d cycles after send, never if d==0), score the frame.
  task automatic serve_frame(input int d, input logic [3:0] drop, input int exp_wait, input string tag);
    exp_t e; int w; int k; bit got; bit stable; bit twice;
    logic [3:0] m; logic [3:0] a; logic [3:0] r; int exp_k;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_scoreboard: queue empty, need an expected frame", tag);
      return;
    end
    e = exp_q.pop_front();
    m = 4'b0001 << e.id;
    exp_k = (d > 0) ? d + 1 : TO + 1;
    got = 0; w = 0;
    while (!got && w < 20) begin
      @(negedge clk);
      if (send === 1'b1) got = 1; else w++;
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL %s_send_seen: no send within 20 cycles, need one", tag);
      return;
    end
    n_cmp++; if (w != exp_wait) begin n_err++; $display("FAIL %s_send_lat: got %0d want %0d", tag, w, exp_wait); end
    n_cmp++; if (grant_id !== 2'(e.id)) begin n_err++; $display("FAIL %s_grant: got %0d want %0d", tag, grant_id, e.id); end
    n_cmp++; if (tx_data !== e.data) begin n_err++; $display("FAIL %s_tx_data: got %h want %h", tag, tx_data, e.data); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy_launch: got %b want 1", tag, busy); end
    k = 0; got = 0; stable = 1; twice = 0; a = '0; r = '0;
    while (!got && k < TO + 100) begin
      @(posedge clk); #1; k++;
      tx_done = (d > 0 && k == d);
      @(negedge clk);
      if (k == 1 && send !== 1'b0) twice = 1;
      if (tx_data !== e.data) stable = 0;
      if (ack !== 4'b0 || err !== 4'b0) begin got = 1; a = ack; r = err; end
    end
    tx_done = 1'b0;
    n_cmp++; if (!got) begin n_err++; $display("FAIL %s_result_seen: no ack/err within %0d cycles", tag, k); end
    n_cmp++; if (k != exp_k) begin n_err++; $display("FAIL %s_result_lat: got %0d want %0d", tag, k, exp_k); end
    n_cmp++; if (a !== (e.ok ? m : 4'b0)) begin n_err++; $display("FAIL %s_ack: got %b want %b", tag, a, e.ok ? m : 4'b0); end
    n_cmp++; if (r !== (e.ok ? 4'b0 : m)) begin n_err++; $display("FAIL %s_err: got %b want %b", tag, r, e.ok ? 4'b0 : m); end
    n_cmp++; if (twice) begin n_err++; $display("FAIL %s_send_width: send high 2 cycles, want 1", tag); end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL %s_tx_data_stable: changed during frame, want %h", tag, e.data); end
    @(posedge clk); #1; req = req & ~drop;
    @(negedge clk);
    n_cmp++; if ({ack, err} !== 8'b0) begin n_err++; $display("FAIL %s_pulse_width: ack=%b err=%b want 0", tag, ack, err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_after: got %b want 0", tag, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (send !== 1'b0) begin n_err++; $display("FAIL reset_send: got %b want 0", send); end
    n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_cmp++; if (err !== 4'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({send, busy} !== 2'b0) begin n_err++; $display("FAIL reset_idle: send=%b busy=%b want 0", send, busy); end
  endtask

  task automatic test_single;
    @(posedge clk); #1; req_data[7:0] = 8'hA5; req = 4'b0001;
    push_exp(0, 8'hA5, 1'b1);
    fork
      serve_frame(1042, 4'b0001, 1, "single");
      begin repeat (4) @(posedge clk); #1; req_data[7:0] = 8'hFF; end
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({ack, err, send} !== 9'b0) begin n_err++; $display("FAIL single_quiet: ack=%b err=%b send=%b want 0", ack, err, send); end
    end
  endtask

  task automatic test_all_request;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111;
    push_exp(0, 8'h11, 1'b1); push_exp(1, 8'h22, 1'b1);
    push_exp(2, 8'h33, 1'b1); push_exp(3, 8'h44, 1'b1);
    serve_frame(40, 4'b0001, 1, "all0");
    serve_frame(45, 4'b0010, 0, "all1");
    serve_frame(50, 4'b0100, 0, "all2");
    serve_frame(55, 4'b1000, 0, "all3");
    n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL all_last_grant: got %0d want 3", grant_id); end
    @(posedge clk); #1; req = 4'b1011;
    push_exp(0, 8'h11, 1'b1); push_exp(1, 8'h22, 1'b1); push_exp(3, 8'h44, 1'b1);
    serve_frame(35, 4'b0001, 1, "wrap0");
    serve_frame(42, 4'b0010, 0, "wrap1");
    serve_frame(49, 4'b1000, 0, "wrap3");
  endtask

  task automatic test_fairness;
    @(posedge clk); #1; req_data[7:0] = 8'hC0; req_data[23:16] = 8'hC2; req = 4'b0101;
    push_exp(0, 8'hC0, 1'b1);
    push_exp(2, 8'hC2, 1'b1); push_exp(0, 8'hC0, 1'b1);
    push_exp(2, 8'hC2, 1'b1); push_exp(0, 8'hC0, 1'b1);
    serve_frame(30, 4'b0000, 1, "fair_a");
    serve_frame(33, 4'b0000, 0, "fair_b");
    serve_frame(36, 4'b0000, 0, "fair_c");
    serve_frame(39, 4'b0000, 0, "fair_d");
    serve_frame(42, 4'b0101, 0, "fair_e");
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL fair_last_grant: got %0d want 0", grant_id); end
  endtask

  task automatic test_timeout;
    @(posedge clk); #1; req_data[23:16] = 8'h5A; req = 4'b0100;
    push_exp(2, 8'h5A, 1'b0);
    fork
      serve_frame(0, 4'b0100, 1, "timeout");
      begin repeat (10) @(posedge clk); #1; req = 4'b0000; end
    join
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL timeout_grant_hold: got %0d want 2", grant_id); end
    @(posedge clk); #1; req_data[15:8] = 8'h77; req = 4'b0010;
    push_exp(1, 8'h77, 1'b1);
    serve_frame(30, 4'b0010, 1, "after_timeout");
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1; tx_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if ({ack, err, send, busy} !== 10'b0) begin n_err++; $display("FAIL stale_done_idle: ack=%b err=%b send=%b busy=%b want 0", ack, err, send, busy); end
    end
    @(posedge clk); #1; req_data[15:8] = 8'hE1; req = 4'b0010;
    push_exp(1, 8'hE1, 1'b1);
    fork
      serve_frame(TO, 4'b0010, 1, "coincide");
      begin @(posedge clk); #1; tx_done = 1'b0; end
    join
  endtask

  task automatic test_reset_mid;
    int w; bit got;
    @(posedge clk); #1; req_data[31:24] = 8'h99; req = 4'b1000;
    w = 0; got = 0;
    while (!got && w < 20) begin
      @(negedge clk);
      if (send === 1'b1) got = 1; else w++;
    end
    n_cmp++; if (!got || grant_id !== 2'd3) begin n_err++; $display("FAIL rstmid_launch: seen=%b grant=%0d want 1/3", got, grant_id); end
    repeat (500) @(posedge clk);
    #1; rst = 1'b1; req = 4'b1010; req_data[15:8] = 8'h3C;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (send !== 1'b0) begin n_err++; $display("FAIL rstmid_send: got %b want 0", send); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rstmid_grant: got %0d want 0", grant_id); end
    n_cmp++; if ({ack, err} !== 8'b0) begin n_err++; $display("FAIL rstmid_no_result: ack=%b err=%b want 0", ack, err); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
    push_exp(1, 8'h3C, 1'b1); push_exp(3, 8'h99, 1'b1);
    serve_frame(45, 4'b0010, 0, "post_rst1");
    serve_frame(60, 4'b1000, 0, "post_rst3");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded 1 ms, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_all_request;
    test_fairness;
    test_timeout;
    test_simultaneous;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
